// File: rtl/dma_mm2s_pkg.sv
// Shared types and defaults for the memory-to-stream DMA read engine.
package dma_mm2s_pkg;
   localparam int WORD_W         = 32;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_LEN_WIDTH  = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;
endpackage

// File: rtl/dma_rd_fifo.sv
// Read-data buffer: circular FIFO with simultaneous push/pop, including at full and empty.
module dma_rd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/dma_mm2s.sv
// Memory-mapped to AXI-Stream DMA: issues credit-limited word reads and streams the
// in-order responses out through a small buffer.
//
// state | meaning
// IDLE  | waiting for cfg_start
// RUN   | issuing reads and streaming words until the last beat is accepted
// FLUSH | one-cycle completion, done high
module dma_mm2s
   import dma_mm2s_pkg::*;
#(
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_start,
   input  logic [31:0]          cfg_base,
   input  logic [LEN_WIDTH-1:0] cfg_len,
   output logic                 busy,
   output logic                 done,
   output logic                 mem_req,
   output logic [31:0]          mem_addr,
   input  logic                 mem_gnt,
   input  logic                 mem_rvalid,
   input  logic [31:0]          mem_rdata,
   output logic                 m_tvalid,
   output logic [31:0]          m_tdata,
   output logic                 m_tlast,
   input  logic                 m_tready
);
   localparam int CNT_W  = LEN_WIDTH + 1;
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int SUM_W  = ((CNT_W > FCNT_W) ? CNT_W : FCNT_W) + 2;

   state_t               state;
   state_t               state_next;
   logic [LEN_WIDTH-1:0] len_q;
   logic [CNT_W-1:0]     issued;
   logic [CNT_W-1:0]     outstanding;
   logic [CNT_W-1:0]     popped;
   logic [CNT_W-1:0]     len_ext;
   logic [CNT_W-1:0]     issued_next;
   logic [SUM_W-1:0]     credit_next;
   logic                 start_ok;
   logic                 grant;
   logic                 rd_accept;
   logic                 beat;
   logic                 mem_req_next;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic [FCNT_W-1:0]    fifo_count;
   logic                 base_unused;

   // Byte-lane bits of the base and the full flag carry no information here.
   assign base_unused = ^{cfg_base[1:0], fifo_full};

   assign start_ok    = (state == IDLE) && cfg_start;
   assign grant       = mem_req && mem_gnt;
   assign rd_accept   = mem_rvalid && (outstanding != '0);
   assign beat        = m_tvalid && m_tready;
   assign len_ext     = CNT_W'(len_q);
   assign issued_next = issued + CNT_W'(grant);

   // Reads in flight plus buffered words after this edge; must stay below depth to issue again.
   assign credit_next = SUM_W'(outstanding) + SUM_W'(fifo_count) + SUM_W'(grant) - SUM_W'(beat);

   assign mem_req_next = (state == RUN) &&
                         ((mem_req && !mem_gnt) ||
                          ((issued_next < len_ext) && (credit_next < SUM_W'(FIFO_DEPTH))));

   assign busy     = (state == RUN);
   assign done     = (state == FLUSH);
   assign m_tvalid = !fifo_empty;
   assign m_tlast  = m_tvalid && (state == RUN) && ((popped + CNT_W'(1)) == len_ext);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (cfg_start) state_next = (cfg_len != '0) ? RUN : FLUSH;
         RUN:     if (beat && m_tlast) state_next = FLUSH;
         FLUSH:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q       <= '0;
         issued      <= '0;
         outstanding <= '0;
         popped      <= '0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
      end else begin
         mem_req <= mem_req_next;
         if (start_ok) begin
            len_q       <= cfg_len;
            issued      <= '0;
            outstanding <= '0;
            popped      <= '0;
            mem_addr    <= {cfg_base[31:2], 2'b00};
         end else begin
            if (grant) begin
               issued   <= issued_next;
               mem_addr <= mem_addr + 32'd4;
            end
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(rd_accept);
            if (beat) popped <= popped + CNT_W'(1);
         end
      end
   end

   dma_rd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WORD_W),
      .CNT_W (FCNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rd_accept),
      .pop   (beat),
      .din   (mem_rdata),
      .dout  (m_tdata),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );
endmodule

// File: tb/tb_dma_mm2s.sv
// Self-checking bench for dma_mm2s: transfer table plus hand-written reset/latency/zero-length sequences.
module tb_dma_mm2s;
   localparam int DEPTH = 4;
   localparam int LW    = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_start;
   logic [31:0]   cfg_base;
   logic [LW-1:0] cfg_len;
   logic          busy, done, mem_req, mem_gnt, mem_rvalid;
   logic [31:0]   mem_addr, mem_rdata, m_tdata;
   logic          m_tvalid, m_tlast, m_tready;

   always #5 clk = ~clk;

   dma_mm2s #(.FIFO_DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base(cfg_base), .cfg_len(cfg_len),
      .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .m_tvalid(m_tvalid), .m_tdata(m_tdata),
      .m_tlast(m_tlast), .m_tready(m_tready)
   );

   typedef struct {
      logic [31:0] base;
      int          len;
      bit          gnt_stall;
      int          bp_after;
      bit          restart;
      int          exp_beats;
      logic [31:0] exp_last_addr;
      int          exp_span;
   } vec_t;

   vec_t        vecs [6];
   int          checks = 0, failures = 0;
   logic [31:0] exp_addr_q [$];
   logic [32:0] exp_beat_q [$];

   int          cyc = 0, grants = 0, beats = 0, lasts = 0, dones = 0, max_inflight = 0;
   int          first_beat_cyc = -1, last_beat_cyc = -1;
   bit          prev_stall = 0, pend_valid = 0, stray = 0, gnt_stall = 0, bp_fired = 0;
   int          bp_after = -1, ready_block = 0, stall_cnt = 0;
   logic [31:0] prev_addr = '0, pend_data = '0, last_grant_addr = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input string detail);
      checks++;
      failures++;
      $display("FAIL %s %s", name, detail);
   endtask

   // Observer: sampled on the falling edge, covering handshakes that complete on the next rising edge.
   always @(negedge clk) begin
      logic [32:0] e;
      cyc++;
      if (rst) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            check("req_hold", 32'(mem_req), 32'd1);
            check("addr_hold", mem_addr, prev_addr);
         end
         prev_stall = mem_req && !mem_gnt;
         prev_addr  = mem_addr;
         if (mem_req && mem_gnt) begin
            grants++;
            last_grant_addr = mem_addr;
            pend_valid      = 1;
            pend_data       = mem_word(mem_addr);
            if (exp_addr_q.size() == 0)
               fail_now("unexpected_grant", $sformatf("actual=0x%08h required=no request", mem_addr));
            else
               check("grant_addr", mem_addr, exp_addr_q.pop_front());
         end
         if (m_tvalid && m_tready) begin
            beats++;
            if (m_tlast) lasts++;
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            if (exp_beat_q.size() == 0) begin
               fail_now("unexpected_beat", $sformatf("actual=0x%08h required=no beat", m_tdata));
            end else begin
               e = exp_beat_q.pop_front();
               check("beat_data", m_tdata, e[31:0]);
               check("beat_last", 32'(m_tlast), 32'(e[32]));
            end
         end
         if (done) begin
            dones++;
            check("busy_low_in_done", 32'(busy), 32'd0);
         end
         if (grants - beats > max_inflight) max_inflight = grants - beats;
      end
   end

   // Memory and sink responder: 1-cycle read latency, optional grant stalls and backpressure.
   initial begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; m_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         mem_rvalid = pend_valid;
         mem_rdata  = pend_valid ? pend_data : 32'h0;
         pend_valid = 0;
         if (stray) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
            stray      = 0;
         end
         if (!gnt_stall) begin
            mem_gnt = 1'b1;
         end else if (mem_req) begin
            if (stall_cnt == 3) begin
               mem_gnt = 1'b1; stall_cnt = 0;
            end else begin
               mem_gnt = 1'b0; stall_cnt++;
            end
         end else begin
            mem_gnt = 1'b0;
         end
         if (bp_after >= 0 && !bp_fired && beats >= bp_after) begin
            ready_block = 10;
            bp_fired    = 1;
         end
         if (ready_block > 0) begin
            m_tready = 1'b0;
            ready_block--;
         end else begin
            m_tready = 1'b1;
         end
      end
   end

   task automatic push_expected(input logic [31:0] base, input int len);
      logic [31:0] a;
      a = {base[31:2], 2'b00};
      for (int i = 0; i < len; i++) begin
         exp_addr_q.push_back(a + 32'(4 * i));
         exp_beat_q.push_back({(i == len - 1), mem_word(a + 32'(4 * i))});
      end
   endtask

   task automatic pulse_start(input logic [31:0] base, input int len);
      @(posedge clk);
      #1;
      cfg_base  = base;
      cfg_len   = LW'(len);
      cfg_start = 1'b1;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int n = 0; n < budget && dones == 0; n++) begin
         @(posedge clk);
         #1;
      end
      if (dones == 0) fail_now("done_timeout", $sformatf("actual=no done required=done within %0d cycles", budget));
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int  b0;
      bit  restarted;
      dones = 0; lasts = 0; max_inflight = 0; first_beat_cyc = -1; b0 = beats;
      push_expected(v.base, v.len);
      gnt_stall = v.gnt_stall; stall_cnt = 0;
      bp_fired  = 0;
      bp_after  = (v.bp_after >= 0) ? beats + v.bp_after : -1;
      pulse_start(v.base, v.len);
      restarted = 0;
      for (int n = 0; n < 3000 && dones == 0; n++) begin
         @(posedge clk);
         #1;
         cfg_start = 1'b0;
         if (v.restart && !restarted && beats - b0 >= 3) begin
            cfg_base  = 32'h9000;
            cfg_len   = LW'(5);
            cfg_start = 1'b1;
            restarted = 1;
         end
      end
      if (dones == 0) fail_now($sformatf("v%0d_done_timeout", idx), "actual=no done required=done");
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("v%0d_beats", idx), 32'(beats - b0), 32'(v.exp_beats));
      check($sformatf("v%0d_tlast_count", idx), 32'(lasts), 32'd1);
      check($sformatf("v%0d_done_count", idx), 32'(dones), 32'd1);
      check($sformatf("v%0d_last_addr", idx), last_grant_addr, v.exp_last_addr);
      check($sformatf("v%0d_inflight_le_depth", idx), 32'(max_inflight <= DEPTH), 32'd1);
      check($sformatf("v%0d_sb_empty", idx), 32'(exp_beat_q.size() + exp_addr_q.size()), 32'd0);
      if (v.exp_span >= 0)
         check($sformatf("v%0d_beat_span", idx), 32'(last_beat_cyc - first_beat_cyc), 32'(v.exp_span));
      gnt_stall = 0;
      bp_after  = -1;
   endtask

   initial begin
      int   lat;
      int   b0;
      vec_t v2;
      vecs[0] = '{32'h0000_1000,  4, 1'b0, -1, 1'b0,  4, 32'h0000_100C,  3};
      vecs[1] = '{32'h0000_4000, 64, 1'b0, 20, 1'b0, 64, 32'h0000_40FC, -1};
      vecs[2] = '{32'h0000_8000,  8, 1'b1, -1, 1'b0,  8, 32'h0000_801C, -1};
      vecs[3] = '{32'h0000_3000, 16, 1'b0, -1, 1'b1, 16, 32'h0000_303C, 15};
      vecs[4] = '{32'hFFFF_FFF8,  4, 1'b0, -1, 1'b0,  4, 32'h0000_0004,  3};
      vecs[5] = '{32'h0000_2003,  1, 1'b0, -1, 1'b0,  1, 32'h0000_2000,  0};

      rst = 1'b1; cfg_start = 1'b0; cfg_base = '0; cfg_len = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl_outputs", 32'({busy, done, mem_req, m_tvalid, m_tlast}), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_m_tdata", m_tdata, 32'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // Start-to-first-valid latency with an uncongested memory.
      dones = 0;
      push_expected(32'h5000, 2);
      pulse_start(32'h5000, 2);
      check("busy_after_start", 32'(busy), 32'd1);
      check("req_not_before_run", 32'(mem_req), 32'd0);
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (m_tvalid) begin
            lat = n;
            break;
         end
      end
      check("start_to_tvalid", 32'(lat), 32'd3);
      wait_done(100);
      check("lat_sb_empty", 32'(exp_beat_q.size()), 32'd0);

      // Zero-length transfer: done the cycle after start, nothing issued or streamed.
      dones = 0; b0 = beats; lat = grants;
      pulse_start(32'h1234_0000, 0);
      check("zero_done_cycle", 32'({done, busy}), 32'b10);
      @(posedge clk);
      #1;
      check("zero_done_single", 32'(done), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("zero_done_count", 32'(dones), 32'd1);
      check("zero_no_req", 32'(grants - lat), 32'd0);
      check("zero_no_beat", 32'(beats - b0), 32'd0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Reset in the middle of a transfer, followed by a stray read response.
      dones = 0; b0 = beats;
      push_expected(32'h6000, 16);
      pulse_start(32'h6000, 16);
      for (int n = 0; n < 500 && beats - b0 < 5; n++) begin
         @(posedge clk);
         #1;
      end
      check("mid_beats_before_rst", 32'(beats - b0), 32'd5);
      rst = 1'b1;
      #1;
      check("mid_rst_ctrl", 32'({busy, done, mem_req, m_tvalid, m_tlast}), 32'd0);
      check("mid_rst_addr", mem_addr, 32'd0);
      check("mid_rst_tdata", m_tdata, 32'd0);
      exp_addr_q.delete();
      exp_beat_q.delete();
      grants = 0; beats = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      stray = 1;
      repeat (4) @(posedge clk);
      #1;
      check("mid_no_done", 32'(dones), 32'd0);
      check("stray_not_streamed", 32'(beats), 32'd0);
      check("stray_no_tvalid", 32'(m_tvalid), 32'd0);
      v2 = '{32'h0000_7000, 2, 1'b0, -1, 1'b0, 2, 32'h0000_7004, 1};
      run_vec(v2, 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout actual=still running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
      $fatal(1, "simulation time limit reached");
   end
endmodule

// File: doc/dma_mm2s.md
DMA_MM2S -- requirements
Module: dma_mm2s

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, meaning the number of read-data buffer entries, equal to the maximum outstanding reads.
REQ-002 Parameter: LEN_WIDTH, default 7, meaning the width of the transfer length in words (maximum 64 words).
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 cfg_start  input  1  single-cycle start pulse.
REQ-007 cfg_base  input  32  byte start address, word-aligned (bits [1:0] are ignored).
REQ-008 cfg_len  input  LEN_WIDTH  transfer length in 32-bit words.
REQ-009 busy  output  1  high from start acceptance until completion.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 mem_req  output  1  read request to memory.
REQ-012 mem_addr  output  32  read byte address.
REQ-013 mem_gnt  input  1  request accepted when mem_req and mem_gnt are both high.
REQ-014 mem_rvalid  input  1  read data valid; responses arrive in order, at least 1 cycle after grant.
REQ-015 mem_rdata  input  32  read data.
REQ-016 m_tvalid  output  1  AXI-Stream master valid, feeding the accelerator slave port.
REQ-017 m_tdata  output  32  stream data.
REQ-018 m_tlast  output  1  high on the final word of the transfer.
REQ-019 m_tready  input  1  downstream ready.

Function
REQ-020 The FSM SHALL have states IDLE, RUN, and FLUSH.
REQ-021 IDLE -> RUN on cfg_start with cfg_len != 0; cfg_base and cfg_len are latched and busy is asserted the next cycle.
REQ-022 IDLE with cfg_start and cfg_len == 0 -> FLUSH; no memory request is issued.
REQ-023 RUN -> FLUSH when the beat carrying m_tlast is accepted (m_tvalid & m_tready & m_tlast).
REQ-024 FLUSH -> IDLE after exactly 1 cycle, during which done is high and busy is low.
REQ-025 cfg_start SHALL be ignored while busy is high.
REQ-026 mem_req SHALL be registered and first asserted the cycle after start acceptance, at the earliest.
REQ-027 mem_req SHALL be raised only when the number of issued words is below cfg_len and (outstanding reads + FIFO occupancy) < FIFO_DEPTH.
REQ-028 While mem_req is high and mem_gnt is low, mem_req and mem_addr SHALL be held stable.
REQ-029 mem_addr SHALL start at cfg_base and add 4 per grant, wrapping modulo 2^32 with no error flag.
REQ-030 Each mem_rvalid SHALL push mem_rdata into the FIFO; the credit rule guarantees no overflow.
REQ-031 The FIFO SHALL support push and pop in the same cycle, including when full or empty.
REQ-032 m_tvalid SHALL equal FIFO non-empty; m_tdata SHALL be the FIFO head.
REQ-033 m_tvalid and m_tdata SHALL remain stable until m_tready is sampled high.
REQ-034 Minimum latency from rvalid to m_tvalid is 1 cycle.
REQ-035 Minimum latency from cfg_start to the first m_tvalid is 3 cycles (1-cycle memory latency).
REQ-036 m_tlast SHALL be high only with the cfg_len-th streamed word, computed from a pop counter and not from memory order.
REQ-037 Sustained throughput SHALL be 1 word/cycle when mem_gnt, m_tready, and 1-cycle rvalid are continuous.
REQ-038 mem_rvalid with zero reads outstanding SHALL be dropped and SHALL NOT be pushed.
REQ-039 The issue, outstanding, and pop counters SHALL be LEN_WIDTH+1 bits wide so that cfg_len at its maximum value is representable.

Reset
REQ-040 On rst the FSM SHALL enter IDLE.
REQ-041 On rst busy, done, mem_req, m_tvalid, and m_tlast SHALL be 0, and mem_addr and m_tdata SHALL be 0.
REQ-042 On rst all counters and FIFO pointers SHALL be cleared.
REQ-043 Reset mid-transfer SHALL abandon the transfer without a done pulse.
REQ-044 Late mem_rvalid responses arriving after reset SHALL be dropped per REQ-038.

Structure
REQ-045 A shared package SHALL hold the state enum {IDLE, RUN, FLUSH}, WORD_W=32, and the default FIFO_DEPTH and LEN_WIDTH values.
REQ-046 There SHALL be one sub-module, dma_rd_fifo (parameterised depth and width, push/pop/empty/full/count); all other logic stays in dma_mm2s.

Verification
REQ-047 Base test: base=0x1000, len=4, mem_gnt=1, 1-cycle rvalid, m_tready=1 -> addresses 0x1000, 0x1004, 0x1008, 0x100C; 4 beats; m_tlast on beat 4; done 1 cycle later.
REQ-048 Backpressure: len=64, m_tready low for 10 cycles mid-stream -> at most FIFO_DEPTH reads outstanding plus buffered, no data loss or reorder, exactly 64 beats, single m_tlast.
REQ-049 Grant stalls: len=8, mem_gnt low for 3 cycles per request -> mem_req and mem_addr held stable through each stall; data order preserved.
REQ-050 Zero length: cfg_len=0 -> no mem_req; done high on the 2nd cycle after cfg_start; no m_tvalid.
REQ-051 Start while busy: a second cfg_start during a len=16 transfer -> ignored; exactly 16 beats.
REQ-052 Reset mid-transfer: rst after beat 5 of a len=16 transfer, followed by a stray rvalid -> all outputs 0, no done pulse, stray data not streamed; a new len=2 transfer then completes normally.
